// File: rtl/pe_feeder.sv
// pe_feeder: sequences one PE pass, streaming filter/ifmap/ipsum words from the GLB and
// writing opsum results back. Define PE_FEEDER_PERF_EN to add the perf_cycles output.
module pe_feeder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [12:0] i_config,
  input  logic [11:0] filter_base,
  input  logic [11:0] ifmap_base,
  input  logic [11:0] ipsum_base,
  input  logic [11:0] opsum_base,
  output logic [11:0] glb_addr,
  output logic        glb_ren,
  input  logic [31:0] glb_rdata,
  output logic        glb_wen,
  output logic [31:0] glb_wdata,
  output logic        pe_en,
  output logic [12:0] pe_config,
  output logic [31:0] filter,
  output logic [31:0] ifmap,
  output logic [31:0] ipsum,
  output logic        filter_valid,
  output logic        ifmap_valid,
  output logic        ipsum_valid,
  input  logic        filter_ready,
  input  logic        ifmap_ready,
  input  logic        ipsum_ready,
  input  logic [31:0] opsum,
  input  logic        opsum_valid,
  output logic        opsum_ready,
  output logic        busy,
  output logic        done
`ifdef PE_FEEDER_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 6;

  typedef enum logic [2:0] {IDLE, CFG, FILTER, IFMAP, IPSUM, OPSUM, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] filt_ptr, ifm_ptr, ips_ptr, ops_ptr;
  logic [CNT_W-1:0]  issue_left, xfer_left, col;
  logic              rd_vld_p1, hold_vld_p1;
  logic [DATA_W-1:0] hold_p1;

  logic [CNT_W-1:0]  rs_n, u_n, p_n, q_n, f_n, nf_n, np_n;
  logic              stream, sink_rdy, word_vld, xfer, issue, last_xfer, op_wr, last_op;
  logic [DATA_W-1:0] word;
  logic [ADDR_W-1:0] rd_addr;

  function automatic logic [CNT_W-1:0] field_p1(input logic [1:0] f);
    return CNT_W'(f) + CNT_W'(1);
  endfunction

  assign rs_n = field_p1(pe_config[11:10]);
  assign u_n  = CNT_W'(pe_config[9]) + CNT_W'(1);
  assign p_n  = field_p1(pe_config[8:7]);
  assign q_n  = field_p1(pe_config[1:0]);
  assign f_n  = CNT_W'(pe_config[6:2]);
  assign nf_n = p_n * rs_n;
  assign np_n = pe_config[12] ? q_n : p_n;

  always_comb begin
    stream   = 1'b0;
    sink_rdy = 1'b0;
    rd_addr  = '0;
    case (state)
      FILTER: begin stream = 1'b1; sink_rdy = filter_ready; rd_addr = filt_ptr; end
      IFMAP:  begin stream = 1'b1; sink_rdy = ifmap_ready;  rd_addr = ifm_ptr;  end
      IPSUM:  begin stream = 1'b1; sink_rdy = ipsum_ready;  rd_addr = ips_ptr;  end
      default: ;
    endcase
  end

  // A fresh GLB word is presented straight from glb_rdata; if not taken it is parked in hold_p1.
  assign word_vld  = rd_vld_p1 | hold_vld_p1;
  assign word      = rd_vld_p1 ? glb_rdata : hold_p1;
  assign xfer      = stream & word_vld & sink_rdy;
  assign issue     = stream & (issue_left != '0) & (~word_vld | sink_rdy);
  assign last_xfer = xfer & (xfer_left == CNT_W'(1));
  assign op_wr     = (state == OPSUM) & opsum_valid;
  assign last_op   = op_wr & (xfer_left == CNT_W'(1));

  assign glb_ren      = issue;
  assign glb_wen      = op_wr;
  assign glb_addr     = issue ? rd_addr : (op_wr ? ops_ptr : '0);
  assign glb_wdata    = op_wr ? opsum : '0;
  assign pe_en        = (state == CFG);
  assign opsum_ready  = (state == OPSUM);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign filter_valid = (state == FILTER) & word_vld;
  assign ifmap_valid  = (state == IFMAP) & word_vld;
  assign ipsum_valid  = (state == IPSUM) & word_vld;
  assign filter       = filter_valid ? word : '0;
  assign ifmap        = ifmap_valid ? word : '0;
  assign ipsum        = ipsum_valid ? word : '0;

  // p1: read data capture
  always_ff @(posedge clk) begin
    if (rd_vld_p1) hold_p1 <= glb_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pe_config   <= '0;
      filt_ptr    <= '0;
      ifm_ptr     <= '0;
      ips_ptr     <= '0;
      ops_ptr     <= '0;
      issue_left  <= '0;
      xfer_left   <= '0;
      col         <= '0;
      rd_vld_p1   <= 1'b0;
      hold_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1   <= issue;
      hold_vld_p1 <= stream & word_vld & ~sink_rdy;
      if (issue) begin
        issue_left <= issue_left - CNT_W'(1);
        case (state)
          FILTER:  filt_ptr <= filt_ptr + ADDR_W'(1);
          IFMAP:   ifm_ptr  <= ifm_ptr + ADDR_W'(1);
          IPSUM:   ips_ptr  <= ips_ptr + ADDR_W'(1);
          default: ;
        endcase
      end
      if (xfer || op_wr) xfer_left <= xfer_left - CNT_W'(1);
      if (op_wr) ops_ptr <= ops_ptr + ADDR_W'(1);
      // Phase loads below take priority over the per-word decrements above.
      case (state)
        IDLE: if (start) begin
          pe_config <= i_config;
          filt_ptr  <= filter_base;
          ifm_ptr   <= ifmap_base;
          ips_ptr   <= ipsum_base;
          ops_ptr   <= opsum_base;
          col       <= '0;
          state     <= CFG;
        end
        CFG: begin
          issue_left <= nf_n;
          xfer_left  <= nf_n;
          state      <= FILTER;
        end
        FILTER: if (last_xfer) begin
          issue_left <= rs_n;
          xfer_left  <= rs_n;
          state      <= IFMAP;
        end
        IFMAP: if (last_xfer) begin
          issue_left <= np_n;
          xfer_left  <= np_n;
          state      <= IPSUM;
        end
        IPSUM: if (last_xfer) begin
          issue_left <= '0;
          xfer_left  <= np_n;
          state      <= OPSUM;
        end
        OPSUM: if (last_op) begin
          if (col == f_n) begin
            state <= DONE;
          end else begin
            col        <= col + CNT_W'(1);
            issue_left <= u_n;
            xfer_left  <= u_n;
            state      <= IFMAP;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PE_FEEDER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     perf_cycles <= '0;
    else if (state == IDLE && start) perf_cycles <= '0;
    else if (state != IDLE)         perf_cycles <= perf_cycles + 32'd1;
  end
`endif
endmodule
